// File: rtl/seven_seg_scan.sv
// -----------------------------------------------------------------------------
// seven_seg_scan
//   Time-multiplexed driver for a NUM_DIGITS-digit 7-segment display.
//   Each digit is a hex nibble with its own decimal point. Digits are scanned
//   round-robin, and each one is held for REFRESH_DIV clock cycles.
//   New values are double-buffered so that the display changes only at frame
//   boundaries. Leading zeros can optionally be blanked.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous reset, active high
//   hex_in     in   [4*NUM_DIGITS-1:0] digit values; nibble i = digit i (0 = LSD)
//   dp_in      in   [NUM_DIGITS-1:0]   decimal point per digit, 1 = lit
//   load       in   capture hex_in/dp_in into the pending buffer
//   blank_lz   in   1 = blank leading zero digits
//   enable     in   0 = display dark and scan frozen
//   seg_out    out  [7:0] {dp,g,f,e,d,c,b,a} of the selected digit, registered
//   an_out     out  [NUM_DIGITS-1:0] one-hot digit select, registered
//   frame_done out  1-cycle pulse after the scan wraps from the last digit to 0
// -----------------------------------------------------------------------------
module seven_seg_scan #(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 1000,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int AN_ACTIVE_LOW  = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [4*NUM_DIGITS-1:0]   hex_in,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  input  logic                      load,
  input  logic                      blank_lz,
  input  logic                      enable,
  output logic [7:0]                seg_out,
  output logic [NUM_DIGITS-1:0]     an_out,
  output logic                      frame_done
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]          presc_q, presc_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0]   pend_hex_q, pend_hex_d;
  logic [NUM_DIGITS-1:0]     pend_dp_q, pend_dp_d;
  logic                      pend_valid_q, pend_valid_d;
  logic [4*NUM_DIGITS-1:0]   act_hex_q, act_hex_d;
  logic [NUM_DIGITS-1:0]     act_dp_q, act_dp_d;
  logic [7:0]                seg_q, seg_d;
  logic [NUM_DIGITS-1:0]     an_q, an_d;
  logic                      frame_done_q, frame_done_d;

  logic                      tick;
  logic                      wrap;
  logic [3:0]                cur_nib;
  logic                      cur_dp;
  logic                      cur_blank;
  logic                      upper_zero;
  logic [NUM_DIGITS-1:0]     lz_blank;

  function automatic logic [6:0] decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  // Scan timing: prescaler and digit index advance only while enabled.
  always_comb begin
    tick    = enable && (presc_q == CNT_LAST);
    wrap    = tick && (idx_q == IDX_LAST);
    presc_d = presc_q;
    idx_d   = idx_q;
    if (enable) begin
      presc_d = tick ? '0 : presc_q + CNT_W'(1);
    end
    if (tick) begin
      idx_d = wrap ? '0 : idx_q + IDX_W'(1);
    end
    frame_done_d = wrap;
  end

  // Double buffer. A load coinciding with the wrap goes straight to the
  // active set, so it is shown in the very next frame; the pending copy is
  // then considered consumed.
  always_comb begin
    pend_hex_d   = pend_hex_q;
    pend_dp_d    = pend_dp_q;
    pend_valid_d = pend_valid_q;
    act_hex_d    = act_hex_q;
    act_dp_d     = act_dp_q;
    if (load) begin
      pend_hex_d   = hex_in;
      pend_dp_d    = dp_in;
      pend_valid_d = 1'b1;
    end
    if (wrap) begin
      pend_valid_d = 1'b0;
      if (load) begin
        act_hex_d = hex_in;
        act_dp_d  = dp_in;
      end else if (pend_valid_q) begin
        act_hex_d = pend_hex_q;
        act_dp_d  = pend_dp_q;
      end
    end
  end

  // Leading-zero map: walk from the most significant digit down. A digit is
  // blanked while every digit at or above it is zero. Digit 0 always shows.
  always_comb begin
    upper_zero = 1'b1;
    lz_blank   = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      upper_zero  = upper_zero & (act_hex_q[4*i +: 4] == 4'h0);
      lz_blank[i] = blank_lz & upper_zero & (i != 0);
    end
  end

  // Select the current digit and form the registered outputs.
  always_comb begin
    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    an_d      = '0;
    seg_d     = 8'h00;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_nib   = act_hex_q[4*i +: 4];
        cur_dp    = act_dp_q[i];
        cur_blank = lz_blank[i];
      end
    end
    if (enable) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        an_d[i] = (idx_q == IDX_W'(i));
      end
      seg_d = {cur_dp, cur_blank ? 7'h00 : decode(cur_nib)};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q      <= '0;
      idx_q        <= '0;
      pend_hex_q   <= '0;
      pend_dp_q    <= '0;
      pend_valid_q <= 1'b0;
      act_hex_q    <= '0;
      act_dp_q     <= '0;
      seg_q        <= 8'h00;
      an_q         <= '0;
      frame_done_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      pend_hex_q   <= pend_hex_d;
      pend_dp_q    <= pend_dp_d;
      pend_valid_q <= pend_valid_d;
      act_hex_q    <= act_hex_d;
      act_dp_q     <= act_dp_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Pin polarity is applied after the flops; it is a static inversion only.
  assign seg_out    = (SEG_ACTIVE_LOW != 0) ? ~seg_q : seg_q;
  assign an_out     = (AN_ACTIVE_LOW != 0) ? ~an_q : an_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// -----------------------------------------------------------------------------
// tb_seven_seg_scan
//   Drives an active-high and an active-low instance of seven_seg_scan with the
//   same stimulus. A frame-level reference model predicts the pins every cycle.
//   Directed frames with hand-computed segment codes pin the model down.
// -----------------------------------------------------------------------------
module tb_seven_seg_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] hex_in;
  logic [3:0]  dp_in;
  logic        load, blank_lz, enable;
  logic [7:0]  seg_h, seg_l;
  logic [3:0]  an_h, an_l;
  logic        fd_h, fd_l;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seven_seg_scan #(.NUM_DIGITS(4), .REFRESH_DIV(4), .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(0)) dut_h (
    .clk(clk), .rst(rst), .hex_in(hex_in), .dp_in(dp_in), .load(load),
    .blank_lz(blank_lz), .enable(enable), .seg_out(seg_h), .an_out(an_h), .frame_done(fd_h));

  seven_seg_scan #(.NUM_DIGITS(4), .REFRESH_DIV(4), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)) dut_l (
    .clk(clk), .rst(rst), .hex_in(hex_in), .dp_in(dp_in), .load(load),
    .blank_lz(blank_lz), .enable(enable), .seg_out(seg_l), .an_out(an_l), .frame_done(fd_l));

  logic [6:0] dec_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference model: scan position as plain counters, frame contents as ints.
  int         m_cnt, m_idx, m_pend_hex, m_pend_dp, m_act_hex, m_act_dp;
  bit         m_pv;
  logic [7:0] exp_seg;
  logic [3:0] exp_an;
  logic       exp_fd;

  function automatic logic [7:0] seg_of(int hexv, int dpv, int idx, logic blz);
    int   upper = hexv >> (4 * idx);
    logic blank = blz && (idx >= 1) && (upper == 0);
    logic dp    = ((dpv >> idx) & 1) != 0;
    return {dp, blank ? 7'h00 : dec_tab[upper & 15]};
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_idx = 0; m_pend_hex = 0; m_pend_dp = 0; m_pv = 0;
    m_act_hex = 0; m_act_dp = 0;
    exp_seg = 8'h00; exp_an = 4'h0; exp_fd = 1'b0;
  endtask

  task automatic model_step();
    bit tick, wrap;
    if (rst) begin
      model_reset();
      return;
    end
    exp_seg = enable ? seg_of(m_act_hex, m_act_dp, m_idx, blank_lz) : 8'h00;
    exp_an  = enable ? 4'(1 << m_idx) : 4'h0;
    tick    = enable && (m_cnt == 3);
    wrap    = tick && (m_idx == 3);
    exp_fd  = wrap;
    if (enable) m_cnt = tick ? 0 : m_cnt + 1;
    if (tick) m_idx = (m_idx + 1) % 4;
    if (wrap) begin
      if (load) begin
        m_act_hex = int'(hex_in); m_act_dp = int'(dp_in);
      end else if (m_pv) begin
        m_act_hex = m_pend_hex; m_act_dp = m_pend_dp;
      end
    end
    if (load) begin
      m_pend_hex = int'(hex_in); m_pend_dp = int'(dp_in);
    end
    m_pv = wrap ? 1'b0 : (load ? 1'b1 : m_pv);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: advance the model with the inputs seen at the edge, compare.
  task automatic cyc();
    @(posedge clk);
    #1;
    model_step();
    chk("seg", seg_h, exp_seg);
    chk("an", {4'h0, an_h}, {4'h0, exp_an});
    chk("fd", {7'h0, fd_h}, {7'h0, exp_fd});
    chk("seg_n", seg_l, ~exp_seg);
    chk("an_n", {4'h0, an_l}, {4'h0, ~exp_an});
    chk("fd_n", {7'h0, fd_l}, {7'h0, exp_fd});
  endtask

  task automatic wait_fd(input string name);
    for (int n = 0; n < 100; n++) begin
      if (fd_h) return;
      cyc();
    end
    checks++;
    errors++;
    $display("FAIL %s frame_done timeout actual=0 required=1", name);
  endtask

  // Expect one whole frame starting after the next frame_done pulse.
  // codes: byte d = seg code of digit d.
  task automatic check_frame(input string name, input logic [31:0] codes);
    wait_fd(name);
    for (int s = 0; s < 16; s++) begin
      cyc();
      chk({name, "_seg"}, seg_h, codes[8*(s/4) +: 8]);
      chk({name, "_an"}, {4'h0, an_h}, {4'h0, 4'(1 << (s/4))});
      chk({name, "_seg_n"}, seg_l, ~codes[8*(s/4) +: 8]);
      chk({name, "_an_n"}, {4'h0, an_l}, {4'h0, ~4'(1 << (s/4))});
    end
  endtask

  initial begin
    logic [7:0] c1234 [4];
    logic [7:0] e;
    c1234 = '{8'h66, 8'h4F, 8'h5B, 8'h06};
    rst = 1'b1; hex_in = '0; dp_in = '0; load = 0; blank_lz = 0; enable = 0;
    #12;
    chk("rst_seg", seg_h, 8'h00);
    chk("rst_an", {4'h0, an_h}, 8'h00);
    chk("rst_fd", {7'h0, fd_h}, 8'h00);
    chk("rst_seg_n", seg_l, 8'hFF);
    chk("rst_an_n", {4'h0, an_l}, 8'h0F);
    model_reset();
    cyc();
    rst = 1'b0;
    enable = 1'b1;
    cyc();

    // Basic decode and scan order
    hex_in = 16'h12AF; dp_in = 4'b0001; load = 1; cyc(); load = 0;
    check_frame("t2", 32'h065B77F1);

    // Leading-zero blanking
    hex_in = 16'h0050; dp_in = 4'b0000; load = 1; blank_lz = 1; cyc(); load = 0;
    check_frame("t3_blank", 32'h00006D3F);
    blank_lz = 0;
    check_frame("t3_noblank", 32'h3F3F6D3F);

    // Mid-frame load does not tear the current frame
    hex_in = 16'h1234; load = 1; cyc(); load = 0;
    check_frame("t4_1234", 32'h065B4F66);
    cyc(); cyc();
    hex_in = 16'h9999; load = 1; cyc(); load = 0;
    for (int n = 0; n < 40 && !fd_h; n++) begin
      e = 8'hEE;
      for (int d = 0; d < 4; d++) if (an_h == 4'(1 << d)) e = c1234[d];
      chk("t4_hold", seg_h, e);
      cyc();
    end
    check_frame("t4_9999", 32'h6F6F6F6F);

    // Load exactly on the wrap edge is used in the next frame
    wait_fd("t5");
    repeat (15) cyc();
    hex_in = 16'hABCD; dp_in = 4'b0000; load = 1; cyc(); load = 0;
    chk("t5_fd", {7'h0, fd_h}, 8'h01);
    cyc();
    chk("t5_seg", seg_h, 8'h5E);
    chk("t5_an", {4'h0, an_h}, 8'h01);
    repeat (5) cyc();
    chk("t5_d1", seg_h, 8'h39);

    // Freeze: dark while disabled, resume in place
    enable = 0;
    repeat (10) begin
      cyc();
      chk("en0_seg", seg_h, 8'h00);
      chk("en0_an", {4'h0, an_h}, 8'h00);
    end
    enable = 1;
    cyc(); chk("resume0_an", {4'h0, an_h}, 8'h02);
    cyc(); chk("resume1_an", {4'h0, an_h}, 8'h02);
    cyc(); chk("resume2_an", {4'h0, an_h}, 8'h04);

    // Randomized traffic, with one asynchronous reset in the middle
    for (int i = 0; i < 1500; i++) begin
      load     = ($urandom % 8) == 0;
      hex_in   = 16'($urandom);
      dp_in    = 4'($urandom);
      enable   = ($urandom % 10) != 0;
      if (($urandom % 16) == 0) blank_lz = ~blank_lz;
      if (i == 700) begin
        #3 rst = 1'b1;
        #1;
        chk("arst_seg", seg_h, 8'h00);
        chk("arst_an", {4'h0, an_h}, 8'h00);
        chk("arst_fd", {7'h0, fd_h}, 8'h00);
        chk("arst_seg_n", seg_l, 8'hFF);
        model_reset();
        cyc();
        rst = 1'b0;
      end
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
